// File: rtl/im_pim_alloc.sv
// Parallel iterative matching allocator between the IM virtual circuits and the central modules.
// Matches persist in a registered crossbar until the owning VC pulses rel.
module im_pim_alloc #(
    parameter int VCN  = 2,
    parameter int CMN  = 2,
    parameter int SN   = 2,
    parameter int ITER = 2,
    parameter int MODE = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [VCN-1:0][SN-1:0]    req,
    input  logic [CMN-1:0][SN-1:0]    cms,
    input  logic [VCN-1:0]            rel,
    output logic [VCN-1:0]            ack,
    output logic [CMN-1:0][VCN-1:0]   cfg,
    output logic                      busy
);

    localparam int VW = (VCN > 1) ? $clog2(VCN) : 1;
    localparam int CW = (CMN > 1) ? $clog2(CMN) : 1;
    localparam int NW = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic {ST_IDLE, ST_ITER} state_e;

    state_e                    state_q, state_d;
    logic [NW-1:0]             cnt_q, cnt_d;
    logic [CMN-1:0][VCN-1:0]   cfg_q, cfg_d;
    logic [CMN-1:0][VW-1:0]    gptr_q, gptr_d;
    logic [VCN-1:0][CW-1:0]    aptr_q, aptr_d;

    logic [VCN-1:0]            vcMatched;
    logic [CMN-1:0]            cmMatched;
    logic [CMN-1:0][VCN-1:0]   elig, grant, accept;
    logic                      anyElig, anyAccept;

    always_comb begin
        vcMatched = '0;
        cmMatched = '0;
        for (int j = 0; j < CMN; j++) begin
            cmMatched[j] = |cfg_q[j];
            for (int i = 0; i < VCN; i++) begin
                vcMatched[i] = vcMatched[i] | cfg_q[j][i];
            end
        end
    end

    // A releasing VC sits out this cycle so its row can clear cleanly.
    always_comb begin
        elig = '0;
        for (int j = 0; j < CMN; j++) begin
            for (int i = 0; i < VCN; i++) begin
                elig[j][i] = !vcMatched[i] && !cmMatched[j] && !rel[i] &&
                             ((MODE == 0) ? (|req[i]) : (|(req[i] & ~cms[j])));
            end
        end
        anyElig = |elig;
    end

    always_comb begin
        logic [VW-1:0] vIdx;
        logic          found;
        grant = '0;
        vIdx  = '0;
        found = 1'b0;
        for (int j = 0; j < CMN; j++) begin
            found = 1'b0;
            for (int k = 0; k < VCN; k++) begin
                vIdx = VW'((int'(gptr_q[j]) + k) % VCN);
                if (!found && elig[j][vIdx]) begin
                    grant[j][vIdx] = 1'b1;
                    found          = 1'b1;
                end
            end
        end
    end

    always_comb begin
        logic [CW-1:0] cIdx;
        logic          found;
        accept = '0;
        cIdx   = '0;
        found  = 1'b0;
        for (int i = 0; i < VCN; i++) begin
            found = 1'b0;
            for (int k = 0; k < CMN; k++) begin
                cIdx = CW'((int'(aptr_q[i]) + k) % CMN);
                if (!found && grant[cIdx][i]) begin
                    accept[cIdx][i] = 1'b1;
                    found           = 1'b1;
                end
            end
        end
        anyAccept = |accept;
    end

    // Only first-iteration accepts move the pointers, which keeps PIM starvation-free.
    always_comb begin
        gptr_d = gptr_q;
        aptr_d = aptr_q;
        if (state_q == ST_ITER && cnt_q == '0) begin
            for (int j = 0; j < CMN; j++) begin
                for (int i = 0; i < VCN; i++) begin
                    if (accept[j][i]) begin
                        gptr_d[j] = VW'((i + 1) % VCN);
                        aptr_d[i] = CW'((j + 1) % CMN);
                    end
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        for (int j = 0; j < CMN; j++) begin
            cfg_d[j] = cfg_q[j] & ~rel;
        end
        case (state_q)
            ST_IDLE: begin
                if (anyElig) begin
                    state_d = ST_ITER;
                    cnt_d   = '0;
                end
            end
            ST_ITER: begin
                cfg_d = cfg_d | accept;
                if (int'(cnt_q) == ITER - 1 || !anyAccept) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cfg_q   <= '0;
            gptr_q  <= '0;
            aptr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cfg_q   <= cfg_d;
            gptr_q  <= gptr_d;
            aptr_q  <= aptr_d;
        end
    end

    assign ack  = vcMatched;
    assign cfg  = cfg_q;
    assign busy = (state_q == ST_ITER);

endmodule

// File: doc/im_pim_alloc.md
IM_PIM_ALLOC -- requirements
Module: im_pim_alloc

Interface
REQ-001 Parameter VCN, default 2: number of virtual circuits (input ports) on the IM.
REQ-002 Parameter CMN, default 2: number of central modules (output ports).
REQ-003 Parameter SN, default 2: number of output directions per VC request.
REQ-004 Parameter ITER, default 2, legal range 1..4: maximum number of PIM iterations per allocation epoch.
REQ-005 Parameter MODE, default 0: 0 = any free CM is eligible; 1 = CM eligibility is masked by the CM direction state.
REQ-006 Port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-007 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 Port req, input, [VCN-1:0][SN-1:0]: per-VC direction requests, held by the VC until ack.
REQ-009 Port cms, input, [CMN-1:0][SN-1:0]: 1 = direction k blocked at CM j; ignored when MODE=0.
REQ-010 Port rel, input, [VCN-1:0]: one-cycle release pulse that frees the VC's match.
REQ-011 Port ack, output, [VCN-1:0]: 1 while the VC holds a match.
REQ-012 Port cfg, output, [CMN-1:0][VCN-1:0]: registered crossbar configuration; cfg[j][i]=1 connects VC i to CM j.
REQ-013 Port busy, output, 1 bit: 1 while the FSM is in ITER.

Function
REQ-014 The VC i/CM j pair shall be eligible when VC i is unmatched, CM j is unmatched, rel[i]=0, and either (MODE=0 and |req[i]) or (MODE=1 and |(req[i] & ~cms[j])).
REQ-015 The FSM shall have states IDLE and ITER; IDLE->ITER when any eligible pair exists, with iteration counter cnt cleared to 0.
REQ-016 Each ITER cycle shall perform one PIM iteration on live inputs: each free CM grants one requesting eligible VC, searching round-robin from gptr[j]; each VC accepts one grant, searching round-robin from aptr[i].
REQ-017 Accepted pairs shall set cfg[j][i] at the ending clock edge; ack[i] = OR over j of cfg[j][i], so ack and cfg rise on the same edge.
REQ-018 Pointers shall update only on iteration 0 accepts: gptr[j] <= (accepted VC + 1) mod VCN; aptr[i] <= (accepted CM + 1) mod CMN; unaccepted grants leave pointers unchanged.
REQ-019 ITER->IDLE when cnt == ITER-1 or the current iteration produces no new match; otherwise cnt increments.
REQ-020 Latency: req asserted in an IDLE cycle t shall yield ack at edge t+2 at the earliest (iteration 0); worst case t+1+ITER.
REQ-021 Each CM column and each VC row of cfg shall be one-hot or zero at all times.
REQ-022 Matched VCs shall ignore req; a match persists, independent of req and cms, until rel.
REQ-023 rel[i] shall clear row i of cfg and ack[i] at the next edge; if rel[i] coincides with an iteration, VC i is not eligible in that cycle.
REQ-024 A req withdrawn before grant shall produce no match; a req withdrawn after ack shall not clear the match.
REQ-025 cms changes shall affect only eligibility of future grants, never existing matches.
REQ-026 A freed CM and a VC still pending shall be reconsidered in the next IDLE cycle without further stimulus.

Reset
REQ-027 While rst=1, cfg=0, ack=0, busy=0, state=IDLE, cnt=0, all gptr/aptr=0, immediately and independent of clk.
REQ-028 Reset asserted mid-ITER shall discard partial matches; after deassertion the first possible ack is 2 edges after the first sampled eligible request.

Verification
REQ-029 Reset: assert rst with VCN=CMN=SN=2 -> cfg=0, ack=2'b00, busy=0; deassert with req=0 -> outputs unchanged for 10 cycles.
REQ-030 Single request: req[0]=2'b01 at cycle 0, MODE=0 -> busy=1 during cycle 1; cfg[0]=2'b01, ack=2'b01 after edge 2; gptr[0]=1, aptr[0]=1.
REQ-031 Contention, ITER=2: req[0]=req[1]=2'b11 at cycle 0 -> edge 2: cfg[0][0]=1; edge 3: cfg[1][1]=1, ack=2'b11; with ITER=1, cfg[1][1] rises at edge 4 instead.
REQ-032 Masking, MODE=1: cms[0]=2'b01, cms[1]=2'b00, req[0]=2'b01 -> cfg[1][0]=1, cfg[0]=0.
REQ-033 Release: from REQ-030's end state, rel[0] pulsed 1 cycle -> next edge cfg=0, ack=2'b00; a simultaneous pending req[1] is granted CM0 within the following 2 edges.
REQ-034 Reset mid-operation: rst asserted during the busy cycle of REQ-031 -> cfg and ack drop to 0 without a clock edge; after release, re-matching follows the REQ-031 timing.
